// File: rtl/mcp3008_spi_slave_model.sv
// MCP3008 SPI ADC responder, SPI mode 0,0, oversampled in the clk domain.
// Optional feature: define MCP3008_LSB_TAIL_EN to shift B1..B9 LSB-first after B0,
// as the real device does; otherwise MISO drives 0 once B0 has been held.
module mcp3008_spi_slave_model #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    input  logic [79:0] ch_data,
    output logic        miso,
    output logic        miso_oe,
    output logic        conv_valid,
    output logic [9:0]  conv_result,
    output logic [2:0]  ch_sel,
    output logic        sgl_diff,
    output logic        busy
);

    localparam int unsigned Depth = SYNC_STAGES + 1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_CONFIG     = 3'd2;
    localparam logic [2:0] ST_SAMPLE     = 3'd3;
    localparam logic [2:0] ST_DATA       = 3'd4;
    localparam logic [2:0] ST_TAIL       = 3'd5;

    logic [Depth-1:0] sclk_q, cs_q, mosi_q;
    logic             sclk_rise, sclk_fall, cs_s, mosi_s;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cfg_q, cfg_d;
    logic       sampled_q, sampled_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic       valid_q, valid_d;
    logic [9:0] result_q, result_d;
    logic [2:0] ch_sel_q, ch_sel_d;
    logic       sgl_q, sgl_d;
    logic       busy_q, busy_d;

    logic [9:0]  ch [8];
    logic [2:0]  pos_idx, neg_idx;
    logic [10:0] diff;
    logic [9:0]  sample_val;

    // Input synchronizers; one extra sclk stage forms the edge strobes, and cs_n/mosi
    // take the same total delay so they line up with the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[Depth-2:0], sclk};
            cs_q   <= {cs_q[Depth-2:0], cs_n};
            mosi_q <= {mosi_q[Depth-2:0], mosi};
        end
    end

    assign sclk_rise = sclk_q[Depth-2] & ~sclk_q[Depth-1];
    assign sclk_fall = ~sclk_q[Depth-2] & sclk_q[Depth-1];
    assign cs_s      = cs_q[Depth-1];
    assign mosi_s    = mosi_q[Depth-1];

    // Channel mux and differential result; pos index equals D2..D0 directly.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            ch[k] = ch_data[10*k +: 10];
        end
        pos_idx = cfg_q[2:0];
        neg_idx = {cfg_q[2:1], ~cfg_q[0]};
        diff    = {1'b0, ch[pos_idx]} - {1'b0, ch[neg_idx]};
        if (cfg_q[3]) begin
            sample_val = ch[pos_idx];
        end else if (diff[10]) begin
            sample_val = 10'd0;
        end else begin
            sample_val = diff[9:0];
        end
    end

    // Frame sequencer: next-state and registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        sampled_d = sampled_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        ch_sel_d  = ch_sel_q;
        sgl_d     = sgl_q;
        busy_d    = busy_q;
        if (state_q != ST_IDLE && cs_s) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!cs_s) state_d = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (sclk_rise && mosi_s) begin
                        state_d = ST_CONFIG;
                        cnt_d   = 4'd0;
                        busy_d  = 1'b1;
                    end
                end
                ST_CONFIG: begin
                    if (sclk_rise) begin
                        cfg_d = {cfg_q[2:0], mosi_s};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd3) begin
                            state_d   = ST_SAMPLE;
                            sampled_d = 1'b0;
                        end
                    end
                end
                ST_SAMPLE: begin
                    // The fall between the last config rise and the sample rise is ignored.
                    if (sclk_rise && !sampled_q) begin
                        sampled_d = 1'b1;
                        valid_d   = 1'b1;
                        result_d  = sample_val;
                        ch_sel_d  = cfg_q[2:0];
                        sgl_d     = cfg_q[3];
                    end else if (sclk_fall && sampled_q) begin
                        oe_d    = 1'b1;
                        miso_d  = 1'b0;
                        cnt_d   = 4'd10;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sclk_fall) begin
                        if (cnt_q != 4'd0) begin
                            miso_d = result_q[cnt_q - 4'd1];
                            cnt_d  = cnt_q - 4'd1;
                        end else begin
                            state_d = ST_TAIL;
`ifdef MCP3008_LSB_TAIL_EN
                            miso_d = result_q[1];
                            cnt_d  = 4'd2;
`else
                            miso_d = 1'b0;
`endif
                        end
                    end
                end
                ST_TAIL: begin
                    if (sclk_fall) begin
`ifdef MCP3008_LSB_TAIL_EN
                        if (cnt_q <= 4'd9) begin
                            miso_d = result_q[cnt_q];
                            cnt_d  = cnt_q + 4'd1;
                        end else begin
                            miso_d = 1'b0;
                        end
`else
                        miso_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            cfg_q     <= 4'd0;
            sampled_q <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= 10'd0;
            ch_sel_q  <= 3'd0;
            sgl_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            sampled_q <= sampled_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            ch_sel_q  <= ch_sel_d;
            sgl_q     <= sgl_d;
            busy_q    <= busy_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = oe_q;
    assign conv_valid  = valid_q;
    assign conv_result = result_q;
    assign ch_sel      = ch_sel_q;
    assign sgl_diff    = sgl_q;
    assign busy        = busy_q;

endmodule
